// File: rtl/neo_pixel_strand_receiver.sv
// neo_pixel_strand_receiver: decodes a WS2812-style serial strand into 24-bit GRB pixels with frame status pulses
module neo_pixel_strand_receiver #(
  parameter int NUM_PIXELS   = 5,
  parameter int T_BIT_THRESH = 26,
  parameter int T_HIGH_MAX   = 60,
  parameter int T_RESET      = 2500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_data,
  output logic [23:0] pixel_data,
  output logic [2:0]  pixel_num,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);
  localparam int LW = $clog2(T_RESET + 1);
  localparam int HW = $clog2(T_HIGH_MAX + 2);
  localparam int PW = $clog2(NUM_PIXELS + 1);
  localparam logic [1:0] WAIT_GAP = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] LOW      = 2'd3;
  logic          s1, d_s, ovf, bit_val;
  logic [1:0]    state;
  logic [LW-1:0] lc;
  logic [HW-1:0] hc;
  logic [PW-1:0] pc;
  logic [4:0]    bc;
  logic [22:0]   sr;
  logic [23:0]   sr_n;
  assign busy = state[1];
  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clock) begin
    s1  <= reset ? 1'b0 : neo_data;
    d_s <= reset ? 1'b0 : s1;
  end
  // decoded bit value and the shift register contents including it
  always_comb begin
    bit_val = hc >= HW'(T_BIT_THRESH);
    sr_n    = {sr, bit_val};
  end
  // frame decoder: gap detection, pulse timing, bit/pixel assembly and frame status
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= WAIT_GAP;
      lc          <= '0;
      hc          <= '0;
      pc          <= '0;
      bc          <= '0;
      sr          <= '0;
      ovf         <= 1'b0;
      pixel_data  <= '0;
      pixel_num   <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        WAIT_GAP: begin
          if (d_s) lc <= '0;
          else if (lc == LW'(T_RESET - 1)) begin
            state <= ARMED;
            lc    <= '0;
          end else lc <= lc + LW'(1);
        end
        ARMED: begin
          if (d_s) begin
            state <= HIGH;
            hc    <= HW'(1);
            bc    <= '0;
            pc    <= '0;
            ovf   <= 1'b0;
          end
        end
        HIGH: begin
          if (d_s) begin
            if (hc >= HW'(T_HIGH_MAX)) begin
              frame_error <= 1'b1;
              state       <= WAIT_GAP;
              lc          <= '0;
            end else hc <= hc + HW'(1);
          end else begin
            sr    <= sr_n[22:0];
            state <= LOW;
            lc    <= LW'(1);
            if (pc == PW'(NUM_PIXELS)) ovf <= 1'b1;
            if (bc == 5'd23) begin
              bc <= '0;
              if (pc < PW'(NUM_PIXELS)) begin
                pixel_data  <= sr_n;
                pixel_num   <= 3'(pc);
                pixel_valid <= 1'b1;
                pc          <= pc + PW'(1);
              end
            end else bc <= bc + 5'd1;
          end
        end
        LOW: begin
          if (d_s) begin
            state <= HIGH;
            hc    <= HW'(1);
          end else if (lc == LW'(T_RESET - 1)) begin
            state <= ARMED;
            lc    <= '0;
            if (pc == PW'(NUM_PIXELS) && bc == 5'd0 && !ovf) frame_done <= 1'b1;
            else frame_error <= 1'b1;
          end else lc <= lc + LW'(1);
        end
      endcase
    end
  end
endmodule

// File: doc/neo_pixel_strand_receiver.md
NEO_PIXEL_STRAND_RECEIVER -- requirements
Module: neo_pixel_strand_receiver

Interface
REQ-001 Parameter NUM_PIXELS, default 5, pixels per frame.
REQ-002 Parameter T_BIT_THRESH, default 26, minimum high-pulse length in clocks decoded as a '1'.
REQ-003 Parameter T_HIGH_MAX, default 60, high-pulse length in clocks above which the frame is an error.
REQ-004 Parameter T_RESET, default 2500, consecutive low clocks that end a frame (50 us at 50 MHz).
REQ-005 clock  input  1  single system clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 neo_data  input  1  asynchronous serial NeoPixel line.
REQ-008 pixel_data  output  24  last decoded pixel, {G[23:16], R[15:8], B[7:0]}.
REQ-009 pixel_num  output  3  index of pixel_data within the frame, 0 = first received.
REQ-010 pixel_valid  output  1  one-cycle pulse when pixel_data and pixel_num update.
REQ-011 frame_done  output  1  one-cycle pulse: frame ended cleanly.
REQ-012 frame_error  output  1  one-cycle pulse: frame ended or aborted malformed.
REQ-013 busy  output  1  high while a frame is being received.

Function
REQ-014 neo_data passes a 2-flop synchronizer; all decoding uses the synchronized signal d_s only.
REQ-015 Bits are MSB first; 24 bits per pixel in order G, R, B.
REQ-016 States: WAIT_GAP, ARMED, HIGH, LOW.
REQ-017 WAIT_GAP: count consecutive d_s=0 clocks, clear count on d_s=1; reaching T_RESET -> ARMED; no decoding here (prevents mid-frame join).
REQ-018 ARMED: d_s=1 -> HIGH with high count = 1, bit count = 0, pixel count = 0.
REQ-019 HIGH: d_s=1 increments high count; high count > T_HIGH_MAX -> frame_error pulse, -> WAIT_GAP.
REQ-020 HIGH, d_s=0: bit = (high count >= T_BIT_THRESH); shift into 24-bit register; bit count++; -> LOW with low count = 1.
REQ-021 On the 24th bit with pixel count < NUM_PIXELS: pixel_data = shift register including this bit, pixel_num = pixel count, pixel_valid pulse, pixel count++, bit count = 0.
REQ-022 Bits arriving after NUM_PIXELS pixels: no pixel_valid; overflow flag set.
REQ-023 LOW: d_s=1 -> HIGH with high count = 1; d_s=0 increments low count; reaching T_RESET -> frame end, -> ARMED.
REQ-024 Frame end: frame_done if pixel count = NUM_PIXELS, bit count = 0 and no overflow; otherwise frame_error (short frame, partial pixel, overflow).
REQ-025 Latency: pixel_valid asserts exactly 3 clocks after the neo_data falling edge of a pixel's 24th bit.
REQ-026 pixel_data and pixel_num hold until the next pixel_valid.
REQ-027 busy = 1 in HIGH and LOW, 0 in WAIT_GAP and ARMED.
REQ-028 frame_done and frame_error never assert together; at most one per frame.
REQ-029 Counters saturate and never wrap: low count at T_RESET, high count at T_HIGH_MAX+1.
REQ-030 High pulse exactly T_BIT_THRESH clocks decodes '1'; T_BIT_THRESH-1 decodes '0'; exactly T_HIGH_MAX clocks is legal.

Reset
REQ-031 While reset is high on a clock edge: state = WAIT_GAP, all counters and flags 0, synchronizer flops 0.
REQ-032 Reset values: pixel_data = 0, pixel_num = 0, pixel_valid = 0, frame_done = 0, frame_error = 0, busy = 0.
REQ-033 Reset mid-frame: partial data discarded, no pulse emitted; receiver re-arms only after T_RESET low clocks.

Verification
REQ-034 Reset, 2500 low clocks, then 5 pixels (pixel 4 G=00 R=FF B=00, others 0) using '0' = 18 high/44 low, '1' = 35 high/28 low clocks, then 2500 low clocks -> five pixel_valid pulses, pixel_num 0..4, pixel 4 pixel_data = 24'h00FF00; one frame_done, no frame_error.
REQ-035 Pixel 24'hA0B3D4 -> pixel_data = 24'hA0B3D4; pixel_valid exactly 3 clocks after the falling edge of the 24th bit.
REQ-036 Boundary pulses of 26 and 25 high clocks -> decoded 1 and 0; 61-clock high pulse -> frame_error, busy drops, no frame_done.
REQ-037 Frame of 4 pixels, or 5 pixels plus 1 extra bit, then gap -> frame_error at the gap, no frame_done; the extra bit produces no pixel_valid.
REQ-038 Start bits without a prior 2500-clock gap after reset -> no pixel_valid; reset asserted mid-pixel -> outputs all 0, the next full gap plus frame decodes correctly.
